// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser_pkg
// Purpose  : Shared definitions for the UART command-frame parser: opcode
//            table (opcodes and payload lengths), FSM state encodings and
//            the opcode lookup helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_parser_pkg;

    // Opcode table
    localparam logic [15:0] OP_DUMP_BOOK     = 16'hFE00;
    localparam logic [15:0] OP_CANCEL_ID     = 16'hFE01;
    localparam logic [15:0] OP_SET_PARAM     = 16'hFE02;
    localparam logic [15:0] OP_PING          = 16'hFE03;

    localparam logic [3:0]  OP_DUMP_BOOK_LEN = 4'd0;
    localparam logic [3:0]  OP_CANCEL_ID_LEN = 4'd4;
    localparam logic [3:0]  OP_SET_PARAM_LEN = 4'd8;
    localparam logic [3:0]  OP_PING_LEN      = 4'd1;

    // FSM state encodings
    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  OP_LO   = 2'd1;
    localparam logic [1:0]  PAYLOAD = 2'd2;

    typedef struct packed {
        logic       known;
        logic [3:0] len;
    } op_info_t;

    // Table lookup. An entry whose payload cannot fit in the configured
    // payload register is reported as unknown rather than truncated.
    function automatic op_info_t op_lookup(input logic [15:0] opcode,
                                           input int          max_payload);
        op_info_t info;
        info.known = 1'b1;
        info.len   = 4'd0;
        case (opcode)
            OP_DUMP_BOOK: info.len = OP_DUMP_BOOK_LEN;
            OP_CANCEL_ID: info.len = OP_CANCEL_ID_LEN;
            OP_SET_PARAM: info.len = OP_SET_PARAM_LEN;
            OP_PING:      info.len = OP_PING_LEN;
            default:      info.known = 1'b0;
        endcase
        if (int'(info.len) > max_payload) begin
            info.known = 1'b0;
        end
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser_idle_timer
// Purpose  : Inter-byte idle timer for the command parser. Counts enabled
//            clocks since the last clear and flags expiry on the clock that
//            completes TIMEOUT_CYCLES idle clocks. TIMEOUT_CYCLES = 0
//            disables expiry.
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            clr    - restart the count (a byte arrived); wins over en
//            en     - count this clock (parser is inside a frame)
//            expire - combinational: this idle clock reaches the limit
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser_idle_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMR_W          = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam bit               c_enabled    = (TIMEOUT_CYCLES != 0);
    // Count holds n-1 during the n-th idle clock, so expiry compares
    // against TIMEOUT_CYCLES-1.
    localparam logic [TMR_W-1:0] c_last_count =
        TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = c_enabled && en && !clr && (r_count == c_last_count);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Parses UART RX bytes into command frames: 16-bit big-endian
//            opcode followed by a per-opcode payload. Completed commands are
//            presented through a one-entry valid/ready holding register.
//            Unknown opcodes, inter-byte timeouts and dropped commands are
//            flagged with single-clock pulses. trigger_dump pulses whenever a
//            DUMP_BOOK (FE00) command loads.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            uart_rx_data_out    - received byte
//            uart_rx_data_valid  - one-clock strobe per byte
//            cmd_valid/cmd_ready - output handshake
//            cmd_opcode/len/payload - held command (payload byte 0 in [7:0])
//            trigger_dump        - legacy book-dump pulse
//            err_unknown/err_timeout/err_overflow - error pulses
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMR_W          = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               uart_rx_data_out,
    input  logic                     uart_rx_data_valid,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [15:0]              cmd_opcode,
    output logic [3:0]               cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic                     trigger_dump,
    output logic                     err_unknown,
    output logic                     err_timeout,
    output logic                     err_overflow
);

    localparam int c_pl_w = 8 * MAX_PAYLOAD;

    // Parser state
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [7:0]        r_op_hi;
    logic [15:0]       r_opcode;
    logic [3:0]        r_len;
    logic [3:0]        r_remaining;
    logic [c_pl_w-1:0] r_acc;

    // Output holding register
    logic              r_cmd_valid;
    logic [15:0]       r_cmd_opcode;
    logic [3:0]        r_cmd_len;
    logic [c_pl_w-1:0] r_cmd_payload;
    logic              r_trigger_dump;
    logic              r_err_unknown;
    logic              r_err_timeout;
    logic              r_err_overflow;

    // Combinational decode
    op_info_t          w_op_info;
    logic [3:0]        w_lane;
    logic [c_pl_w-1:0] w_acc_next;
    logic              w_in_frame;
    logic              w_expire;
    logic              w_unknown;
    logic              w_complete;
    logic              w_timeout;
    logic [15:0]       w_done_opcode;
    logic [3:0]        w_done_len;
    logic [c_pl_w-1:0] w_done_payload;

    uart_cmd_parser_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (uart_rx_data_valid),
        .en     (w_in_frame),
        .expire (w_expire)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A byte always wins over a coincident expiry.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (uart_rx_data_valid) begin
                    w_state_next = OP_LO;
                end
            end
            OP_LO: begin
                if (uart_rx_data_valid) begin
                    if (!w_op_info.known || (w_op_info.len == 4'd0)) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = PAYLOAD;
                    end
                end else if (w_expire) begin
                    w_state_next = IDLE;
                end
            end
            PAYLOAD: begin
                if (uart_rx_data_valid) begin
                    if (r_remaining == 4'd1) begin
                        w_state_next = IDLE;
                    end
                end else if (w_expire) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / decode
    // ------------------------------------------------------------------
    always_comb begin
        w_op_info  = op_lookup({r_op_hi, uart_rx_data_out}, MAX_PAYLOAD);
        w_in_frame = (r_state == OP_LO) || (r_state == PAYLOAD);
        w_lane     = r_len - r_remaining;

        w_acc_next = r_acc;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (w_lane == 4'(i)) begin
                w_acc_next[i*8 +: 8] = uart_rx_data_out;
            end
        end

        w_unknown  = uart_rx_data_valid && (r_state == OP_LO) && !w_op_info.known;
        w_complete = uart_rx_data_valid &&
                     (((r_state == OP_LO) && w_op_info.known && (w_op_info.len == 4'd0)) ||
                      ((r_state == PAYLOAD) && (r_remaining == 4'd1)));
        w_timeout  = !uart_rx_data_valid && w_in_frame && w_expire;

        // Zero-length commands complete from OP_LO; the accumulator was
        // cleared at frame start, so unused lanes are always zero.
        if (r_state == OP_LO) begin
            w_done_opcode  = {r_op_hi, uart_rx_data_out};
            w_done_len     = 4'd0;
            w_done_payload = '0;
        end else begin
            w_done_opcode  = r_opcode;
            w_done_len     = r_len;
            w_done_payload = w_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_hi     <= '0;
            r_opcode    <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_acc       <= '0;
        end else if (uart_rx_data_valid) begin
            case (r_state)
                IDLE: begin
                    r_op_hi <= uart_rx_data_out;
                    r_acc   <= '0;
                end
                OP_LO: begin
                    if (w_op_info.known) begin
                        r_opcode    <= {r_op_hi, uart_rx_data_out};
                        r_len       <= w_op_info.len;
                        r_remaining <= w_op_info.len;
                    end
                end
                PAYLOAD: begin
                    r_acc       <= w_acc_next;
                    r_remaining <= r_remaining - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output holding register and status pulses. A completion on the
    // same clock as a consumer accept replaces the held entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid    <= 1'b0;
            r_cmd_opcode   <= '0;
            r_cmd_len      <= '0;
            r_cmd_payload  <= '0;
            r_trigger_dump <= 1'b0;
            r_err_unknown  <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_trigger_dump <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_unknown  <= w_unknown;
            r_err_timeout  <= w_timeout;
            if (w_complete) begin
                if (r_cmd_valid && !cmd_ready) begin
                    r_err_overflow <= 1'b1;
                end else begin
                    r_cmd_valid    <= 1'b1;
                    r_cmd_opcode   <= w_done_opcode;
                    r_cmd_len      <= w_done_len;
                    r_cmd_payload  <= w_done_payload;
                    r_trigger_dump <= (w_done_opcode == OP_DUMP_BOOK);
                end
            end else if (cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_opcode   = r_cmd_opcode;
    assign cmd_len      = r_cmd_len;
    assign cmd_payload  = r_cmd_payload;
    assign trigger_dump = r_trigger_dump;
    assign err_unknown  = r_err_unknown;
    assign err_timeout  = r_err_timeout;
    assign err_overflow = r_err_overflow;

endmodule
`default_nettype wire
